// File: rtl/baud_gen_os.sv
`default_nettype none
// ============================================================================
// baud_gen_os : fractional-divisor UART baud generator (oversample/bit/mid-bit ticks)
// Revision    : 1.0
// ============================================================================
module baud_gen_os #(
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16,
   parameter int FRAC_W     = 4,
   parameter int DEF_INT    = 27,
   parameter int DEF_FRAC   = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              ena,
   input  logic              resync,
   input  logic [DIV_W-1:0]  cfg_int,
   input  logic [FRAC_W-1:0] cfg_frac,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              os_tick,
   output logic              bit_tick,
   output logic              half_tick
);

   localparam int SUB_W = $clog2(OVERSAMPLE);
   localparam logic [SUB_W-1:0]  c_HALF    = SUB_W'(OVERSAMPLE / 2);
   localparam logic [DIV_W-1:0]  c_MIN_INT = DIV_W'(2);

   logic [DIV_W:0]    r_oc;
   logic [SUB_W-1:0]  r_sub;
   logic [FRAC_W-1:0] r_acc;
   logic [DIV_W-1:0]  r_int;
   logic [FRAC_W-1:0] r_frac;
   logic              r_pend;
   logic [DIV_W-1:0]  r_pint;
   logic [FRAC_W-1:0] r_pfrac;

   logic              w_os;
   logic              w_bit;
   logic              w_apply;
   logic [DIV_W-1:0]  w_int_use;
   logic [FRAC_W-1:0] w_frac_use;
   logic [FRAC_W-1:0] w_acc_base;
   logic [FRAC_W:0]   w_sum;
   logic [DIV_W:0]    w_reload;
   logic [DIV_W-1:0]  w_cfg_clamped;

   assign w_os      = rstn & ena & ~resync & (r_oc == '0);
   assign w_bit     = w_os & (r_sub == '0);
   assign os_tick   = w_os;
   assign bit_tick  = w_bit;
   assign half_tick = w_os & (r_sub == c_HALF);
   assign cfg_ready = ~r_pend;

   // A pending divisor lands only on a bit boundary or while the generator is idle;
   // the accumulator restarts from zero so the new rate has a clean phase.
   assign w_apply    = r_pend & (~ena | w_bit);
   assign w_int_use  = w_apply ? r_pint  : r_int;
   assign w_frac_use = w_apply ? r_pfrac : r_frac;
   assign w_acc_base = w_apply ? '0      : r_acc;
   assign w_sum      = {1'b0, w_acc_base} + {1'b0, w_frac_use};
   assign w_reload   = {1'b0, w_int_use} - (DIV_W+1)'(1) + {{DIV_W{1'b0}}, w_sum[FRAC_W]};

   assign w_cfg_clamped = (cfg_int < c_MIN_INT) ? c_MIN_INT : cfg_int;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_oc    <= '0;
         r_sub   <= '0;
         r_acc   <= '0;
         r_int   <= DIV_W'(DEF_INT);
         r_frac  <= FRAC_W'(DEF_FRAC);
         r_pend  <= 1'b0;
         r_pint  <= '0;
         r_pfrac <= '0;
      end else begin
         if (cfg_valid && !r_pend) begin
            r_pend  <= 1'b1;
            r_pint  <= w_cfg_clamped;
            r_pfrac <= cfg_frac;
         end else if (w_apply) begin
            r_pend <= 1'b0;
         end
         if (w_apply) begin
            r_int  <= r_pint;
            r_frac <= r_pfrac;
         end

         if (!ena || resync) begin
            r_oc  <= '0;
            r_sub <= '0;
            r_acc <= '0;
         end else if (w_os) begin
            r_oc  <= w_reload;
            r_sub <= r_sub + SUB_W'(1);
            r_acc <= w_sum[FRAC_W-1:0];
         end else if (r_oc != '0) begin
            r_oc <= r_oc - (DIV_W+1)'(1);
         end
      end
   end

endmodule
`default_nettype wire
